// File: rtl/branch_unit_if.sv
// branch_unit_if
//   Bundles the status, sequencing and branch handshake signals between the
//   datapath/controller (master) and the branch unit (slave).
//
//   master -> slave : load_stat, stat_in[2:0] {V,N,Z}, pc_inc, br_req,
//                     br_cond[2:0], br_imm[IMM_W-1:0], rd_val[15:0]
//   slave -> master : pc_out[PC_W-1:0], flags[2:0], busy, br_done, taken,
//                     link_we, link_val[15:0]
interface branch_unit_if #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned IMM_W = 8
);
  logic             load_stat;
  logic [2:0]       stat_in;
  logic             pc_inc;
  logic             br_req;
  logic [2:0]       br_cond;
  logic [IMM_W-1:0] br_imm;
  logic [15:0]      rd_val;

  logic [PC_W-1:0]  pc_out;
  logic [2:0]       flags;
  logic             busy;
  logic             br_done;
  logic             taken;
  logic             link_we;
  logic [15:0]      link_val;

  modport master (
    output load_stat, stat_in, pc_inc, br_req, br_cond, br_imm, rd_val,
    input  pc_out, flags, busy, br_done, taken, link_we, link_val
  );

  modport slave (
    input  load_stat, stat_in, pc_inc, br_req, br_cond, br_imm, rd_val,
    output pc_out, flags, busy, br_done, taken, link_we, link_val
  );
endinterface

// File: rtl/branch_unit.sv
// branch_unit
//   Holds the program counter and the {V,N,Z} flag register. A branch request
//   accepted in IDLE is evaluated against the latched flags in EVAL and the
//   resulting PC is committed in COMMIT, followed by a one-cycle br_done pulse
//   (and link_we for BL/BLX).
//
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : branch_unit_if.slave (status, pc_inc, branch request/response)
module branch_unit #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned IMM_W = 8
) (
  input logic          clk,
  input logic          reset,
  branch_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StEval, StCommit} state_e;

  localparam logic [2:0] CondB   = 3'd0;
  localparam logic [2:0] CondBeq = 3'd1;
  localparam logic [2:0] CondBne = 3'd2;
  localparam logic [2:0] CondBlt = 3'd3;
  localparam logic [2:0] CondBle = 3'd4;
  localparam logic [2:0] CondBl  = 3'd5;
  localparam logic [2:0] CondBx  = 3'd6;
  localparam logic [2:0] CondBlx = 3'd7;

  state_e           r_state, w_state_d;

  logic [PC_W-1:0]  r_pc;
  logic [2:0]       r_flags;

  // Snapshot of the request taken when leaving IDLE.
  logic [2:0]       r_cond;
  logic [IMM_W-1:0] r_imm;
  logic [PC_W-1:0]  r_rd_tgt;
  logic [PC_W-1:0]  r_pc_cur;

  // Result of EVAL, consumed in COMMIT.
  logic             r_br_taken;
  logic [PC_W-1:0]  r_target;

  logic             r_taken;
  logic             r_done;
  logic             r_link_we;
  logic [15:0]      r_link_val;

  logic             w_taken_eval;
  logic [PC_W-1:0]  w_seq;
  logic [PC_W-1:0]  w_imm_ext;
  logic [PC_W-1:0]  w_target;
  logic             w_is_link;
  logic             w_z, w_n, w_v;

  assign w_z = r_flags[0];
  assign w_n = r_flags[1];
  assign w_v = r_flags[2];

  assign w_seq     = r_pc_cur + PC_W'(1);
  // Size cast of a signed operand sign-extends the immediate.
  assign w_imm_ext = PC_W'($signed(r_imm));
  assign w_is_link = (r_cond == CondBl) || (r_cond == CondBlx);

  always_comb begin
    w_taken_eval = 1'b1;
    unique case (r_cond)
      CondBeq: w_taken_eval = w_z;
      CondBne: w_taken_eval = ~w_z;
      CondBlt: w_taken_eval = w_n ^ w_v;
      CondBle: w_taken_eval = (w_n ^ w_v) | w_z;
      CondB, CondBl, CondBx, CondBlx: w_taken_eval = 1'b1;
      default: w_taken_eval = 1'b1;
    endcase
  end

  always_comb begin
    w_target = w_seq + w_imm_ext;
    if ((r_cond == CondBx) || (r_cond == CondBlx)) begin
      w_target = r_rd_tgt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (bus.br_req) w_state_d = StEval;
      StEval:   w_state_d = StCommit;
      StCommit: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= '0;
      r_flags    <= '0;
      r_cond     <= '0;
      r_imm      <= '0;
      r_rd_tgt   <= '0;
      r_pc_cur   <= '0;
      r_br_taken <= 1'b0;
      r_target   <= '0;
      r_taken    <= 1'b0;
      r_done     <= 1'b0;
      r_link_we  <= 1'b0;
      r_link_val <= '0;
    end else begin
      // Flags load in any state; EVAL reads the value already in the register.
      if (bus.load_stat) r_flags <= bus.stat_in;
      r_done    <= 1'b0;
      r_link_we <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.br_req) begin
            r_cond   <= bus.br_cond;
            r_imm    <= bus.br_imm;
            r_rd_tgt <= bus.rd_val[PC_W-1:0];
            r_pc_cur <= r_pc;
          end else if (bus.pc_inc) begin
            r_pc <= r_pc + PC_W'(1);
          end
        end
        StEval: begin
          r_br_taken <= w_taken_eval;
          r_target   <= w_target;
        end
        StCommit: begin
          r_pc       <= r_br_taken ? r_target : w_seq;
          r_taken    <= r_br_taken;
          r_done     <= 1'b1;
          r_link_we  <= w_is_link;
          r_link_val <= 16'(w_seq);
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_out   = r_pc;
  assign bus.flags    = r_flags;
  assign bus.busy     = (r_state != StIdle);
  assign bus.br_done  = r_done;
  assign bus.taken    = r_taken;
  assign bus.link_we  = r_link_we;
  assign bus.link_val = r_link_val;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;
  localparam int unsigned PC_W  = 9;
  localparam int unsigned IMM_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_unit_if #(.PC_W(PC_W), .IMM_W(IMM_W)) bus ();

  branch_unit #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A branch is a two-cycle delayed event; flags seen by it are those present
  // right after the accepting edge.
  int         m_pc;
  logic [2:0] m_flags;
  int         m_cnt;
  bit         m_done, m_link_we, m_taken, m_valid = 1'b0;
  int         m_link_val;
  int         p_pc_cur, p_target;
  bit         p_taken, p_link;
  logic [2:0] f_now;

  function automatic bit cond_taken(input logic [2:0] c, input logic [2:0] f);
    bit z = f[0];
    bit n = f[1];
    bit v = f[2];
    case (c)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n ^ v;
      3'd4:    return (n ^ v) | z;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int branch_target(input logic [2:0] c, input int pc_cur,
                                       input logic [7:0] imm, input logic [15:0] rd);
    if (c == 3'd6 || c == 3'd7) return int'(rd) % 512;
    return (pc_cur + 1 + int'($signed(imm))) & 511;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_flags = 3'b000; m_cnt = 0; m_done = 0; m_link_we = 0;
      m_taken = 0; m_link_val = 0; m_valid = 1;
    end else begin
      f_now = bus.load_stat ? bus.stat_in : m_flags;
      m_done = 0;
      m_link_we = 0;
      if (m_cnt == 0) begin
        if (bus.br_req) begin
          p_pc_cur = m_pc;
          p_taken  = cond_taken(bus.br_cond, f_now);
          p_target = branch_target(bus.br_cond, m_pc, bus.br_imm, bus.rd_val);
          p_link   = (bus.br_cond == 3'd5) || (bus.br_cond == 3'd7);
          m_cnt    = 2;
        end else if (bus.pc_inc) begin
          m_pc = (m_pc + 1) % 512;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_pc       = p_taken ? p_target : (p_pc_cur + 1) % 512;
          m_taken    = p_taken;
          m_done     = 1;
          m_link_we  = p_link;
          m_link_val = (p_pc_cur + 1) % 512;
        end
      end
      if (bus.load_stat) m_flags = bus.stat_in;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_pc_out", 32'(bus.pc_out), m_pc);
      check("m_flags", 32'(bus.flags), 32'(m_flags));
      check("m_busy", 32'(bus.busy), 32'(m_cnt != 0));
      check("m_br_done", 32'(bus.br_done), 32'(m_done));
      check("m_taken", 32'(bus.taken), 32'(m_taken));
      check("m_link_we", 32'(bus.link_we), 32'(m_link_we));
      if (m_link_we) check("m_link_val", 32'(bus.link_val), m_link_val);
    end
  end

  // ---------------- stimulus ----------------
  task automatic go_pc(input int n);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (n) begin
      bus.pc_inc = 1'b1;
      @(negedge clk);
    end
    bus.pc_inc = 1'b0;
  endtask

  task automatic load(input logic [2:0] s);
    bus.load_stat = 1'b1;
    bus.stat_in   = s;
    @(negedge clk);
    bus.load_stat = 1'b0;
  endtask

  // Issues a branch and returns in the br_done cycle.
  task automatic branch(input logic [2:0] c, input logic [7:0] imm, input logic [15:0] rd,
                        input int exp_eval_pc, input bit noise, input bit inc_req,
                        input bit ld_req, input logic [2:0] ld_val);
    bus.br_req = 1'b1; bus.br_cond = c; bus.br_imm = imm; bus.rd_val = rd;
    bus.pc_inc = inc_req; bus.load_stat = ld_req; bus.stat_in = ld_val;
    @(negedge clk);
    bus.br_req = 1'b0; bus.pc_inc = 1'b0; bus.load_stat = 1'b0;
    check("busy_eval", 32'(bus.busy), 1);
    check("pc_eval", 32'(bus.pc_out), exp_eval_pc);
    if (noise) begin
      bus.pc_inc = 1'b1; bus.br_req = 1'b1; bus.br_cond = 3'd0; bus.br_imm = 8'h40;
      bus.rd_val = 16'h01AA; bus.load_stat = 1'b1; bus.stat_in = 3'b001;
    end
    @(negedge clk);
    check("busy_commit", 32'(bus.busy), 1);
    @(negedge clk);
    bus.pc_inc = 1'b0; bus.br_req = 1'b0; bus.load_stat = 1'b0;
    check("br_done_latency", 32'(bus.br_done), 1);
  endtask

  initial begin
    bus.load_stat = 0; bus.stat_in = 0; bus.pc_inc = 0; bus.br_req = 0;
    bus.br_cond = 0; bus.br_imm = 0; bus.rd_val = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", 32'(bus.pc_out), 0);
    check("rst_link_val", 32'(bus.link_val), 0);

    // Sequential advance
    go_pc(3);
    check("inc3_pc", 32'(bus.pc_out), 3);
    check("inc3_flags", 32'(bus.flags), 0);
    check("inc3_busy", 32'(bus.busy), 0);
    check("inc3_done", 32'(bus.br_done), 0);

    // BEQ taken / not taken
    go_pc(16); load(3'b001);
    branch(3'd1, 8'h05, 16'h0, 16, 0, 0, 0, 3'b000);
    check("beq_t_taken", 32'(bus.taken), 1);
    check("beq_t_pc", 32'(bus.pc_out), 32'h016);
    @(negedge clk);
    check("beq_t_done_clear", 32'(bus.br_done), 0);
    go_pc(16); load(3'b000);
    branch(3'd1, 8'h05, 16'h0, 16, 0, 0, 0, 3'b000);
    check("beq_nt_taken", 32'(bus.taken), 0);
    check("beq_nt_pc", 32'(bus.pc_out), 32'h011);

    // BLT backward, not taken, B wrap
    go_pc(3); load(3'b010);
    branch(3'd3, 8'hFC, 16'h0, 3, 0, 0, 0, 3'b000);
    check("blt_t_pc", 32'(bus.pc_out), 32'h000);
    go_pc(3); load(3'b110);
    branch(3'd3, 8'hFC, 16'h0, 3, 0, 0, 0, 3'b000);
    check("blt_nt_pc", 32'(bus.pc_out), 32'h004);
    go_pc(0);
    branch(3'd0, 8'hFE, 16'h0, 0, 0, 0, 0, 3'b000);
    check("b_wrap_pc", 32'(bus.pc_out), 32'h1FF);

    // BLX / BX / back-to-back BL
    go_pc(32);
    branch(3'd7, 8'h00, 16'h0123, 32, 0, 0, 0, 3'b000);
    check("blx_pc", 32'(bus.pc_out), 32'h123);
    check("blx_link_we", 32'(bus.link_we), 1);
    check("blx_link_val", 32'(bus.link_val), 32'h021);
    @(negedge clk);
    check("blx_link_we_clear", 32'(bus.link_we), 0);
    go_pc(32);
    branch(3'd6, 8'h00, 16'h0123, 32, 0, 0, 0, 3'b000);
    check("bx_pc", 32'(bus.pc_out), 32'h123);
    check("bx_link_we", 32'(bus.link_we), 0);
    branch(3'd5, 8'h02, 16'h0, 32'h123, 0, 0, 0, 3'b000);
    check("bl_b2b_pc", 32'(bus.pc_out), 32'h126);
    check("bl_b2b_link_val", 32'(bus.link_val), 32'h124);

    // Simultaneous and mid-operation events
    go_pc(5);
    branch(3'd2, 8'h10, 16'h0, 5, 0, 1, 0, 3'b000);
    check("req_inc_pc", 32'(bus.pc_out), 32'h016);
    go_pc(7);
    branch(3'd4, 8'h20, 16'h0, 7, 1, 0, 0, 3'b000);
    check("busy_noise_pc", 32'(bus.pc_out), 32'h008);
    check("busy_noise_taken", 32'(bus.taken), 0);
    check("busy_noise_flags", 32'(bus.flags), 32'h1);
    go_pc(8);
    branch(3'd1, 8'h03, 16'h0, 8, 0, 0, 1, 3'b001);
    check("ld_with_req_taken", 32'(bus.taken), 1);
    check("ld_with_req_pc", 32'(bus.pc_out), 32'h00C);

    // Reset during EVAL
    go_pc(80); load(3'b101);
    bus.br_req = 1'b1; bus.br_cond = 3'd0; bus.br_imm = 8'h10;
    @(negedge clk);
    bus.br_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_pc", 32'(bus.pc_out), 0);
    check("abort_flags", 32'(bus.flags), 0);
    check("abort_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", 32'(bus.br_done), 0);
      @(negedge clk);
    end
    branch(3'd0, 8'h02, 16'h0, 0, 0, 0, 0, 3'b000);
    check("after_abort_pc", 32'(bus.pc_out), 32'h003);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
